// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: busy for XLEN cycles after acceptance, done pulse and registered result in cycle XLEN+1.
// Backpressure: start is only taken while busy is low (IDLE or DONE); requests during CALC are dropped.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] opA_i,
    input  logic [XLEN-1:0] opB_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic              div_zero_q;
    logic [XLEN-1:0]   operand_q;   // multiplicand |A| for multiply, divisor |B| for divide
    logic [XLEN-1:0]   raw_a_q;     // untouched dividend, returned as remainder on divide by zero
    logic [XLEN-1:0]   rem_q;
    logic [2*XLEN-1:0] acc_q;       // {product high, multiplier/product low} or {0, dividend/quotient}
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Request decode
    logic              in_neg_a;
    logic              in_neg_b;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    // Iteration and final-result datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   rem_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_d;

    // Decode operand signedness from funct3 and reduce signed negatives to magnitudes
    always_comb begin
        in_neg_a = 1'b0;
        in_neg_b = 1'b0;
        if (funct3_i[2]) begin
            // DIV and REM are signed on both operands; DIVU and REMU on neither
            in_neg_a = ~funct3_i[0] & opA_i[XLEN-1];
            in_neg_b = ~funct3_i[0] & opB_i[XLEN-1];
        end else begin
            in_neg_a = ((funct3_i == 3'b001) || (funct3_i == 3'b010)) & opA_i[XLEN-1];
            in_neg_b = (funct3_i == 3'b001) & opB_i[XLEN-1];
        end
        a_mag = in_neg_a ? -opA_i : opA_i;
        b_mag = in_neg_b ? -opB_i : opB_i;
    end

    // One multiply or divide step, plus sign fix-up and result select for the final step
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, operand_q} : '0);
        rem_shift = {rem_q, acc_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, operand_q};
        div_ge    = (rem_shift >= {1'b0, operand_q});
        acc_d     = acc_q;
        rem_d     = rem_q;
        if (op_q[2]) begin
            // Restoring step: remainder stays below the divisor, so XLEN bits hold it
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
            rem_d = div_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_d : acc_d;
        // Signed overflow needs no special path: |MIN| / 1 = MIN, and negating MIN yields MIN
        quot_fix = div_zero_q ? '1 :
                   ((neg_a_q ^ neg_b_q) ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0]);
        rem_fix  = div_zero_q ? raw_a_q : (neg_a_q ? -rem_d : rem_d);

        case (op_q)
            3'b000:         result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: result_d = quot_fix;
            default:        result_d = rem_fix;
        endcase
    end

    // Control FSM with registered busy/done/result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            operand_q  <= '0;
            raw_a_q    <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q       <= funct3_i;
                        neg_a_q    <= in_neg_a;
                        neg_b_q    <= in_neg_b;
                        div_zero_q <= funct3_i[2] && (opB_i == '0);
                        raw_a_q    <= opA_i;
                        rem_q      <= '0;
                        cnt_q      <= CW'(XLEN - 1);
                        if (funct3_i[2]) begin
                            operand_q <= b_mag;
                            acc_q     <= {{XLEN{1'b0}}, a_mag};
                        end else begin
                            operand_q <= a_mag;
                            acc_q     <= {{XLEN{1'b0}}, b_mag};
                        end
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (cnt_q == '0) begin
                        result_q <= result_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN = 32 and XLEN = 64.
// Expected results are queued when a request is issued and popped on done.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32;
    logic        start64;
    logic [2:0]  funct3;
    logic [63:0] opA;
    logic [63:0] opB;
    logic        busy32, done32;
    logic [31:0] res32;
    logic        busy64, done64;
    logic [63:0] res64;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start32), .funct3_i(funct3),
        .opA_i(opA[31:0]), .opB_i(opB[31:0]),
        .busy_o(busy32), .done_o(done32), .result_o(res32)
    );

    muldiv_unit #(.XLEN(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .start_i(start64), .funct3_i(funct3),
        .opA_i(opA), .opB_i(opB),
        .busy_o(busy64), .done_o(done64), .result_o(res64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 unit after a rising edge: that cycle is cycle 0 of the request.
    task automatic run(input bit w64, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input bit poke, input string tag);
        int lat;
        int done_cyc;
        int busy_bad;
        logic bsy, dn;
        logic [63:0] res, e;
        lat      = w64 ? 64 : 32;
        done_cyc = -1;
        busy_bad = 0;
        funct3 = f3;
        opA    = a;
        opB    = b;
        if (w64) start64 = 1'b1; else start32 = 1'b1;
        exp_q.push_back(w64 ? exp : {32'h0, exp[31:0]});
        for (int c = 1; c <= lat + 10 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            // Scramble inputs after acceptance; optionally pulse start mid-operation
            opA    = {$urandom, $urandom};
            opB    = {$urandom, $urandom};
            funct3 = 3'($urandom_range(0, 7));
            if (w64) start64 = poke && (c == 10); else start32 = poke && (c == 10);
            bsy = w64 ? busy64 : busy32;
            dn  = w64 ? done64 : done32;
            res = w64 ? res64 : {32'h0, res32};
            if (bsy !== (c <= lat)) busy_bad++;
            if (dn === 1'b1) begin
                done_cyc = c;
                check({tag, "_sb_size"}, 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_result"}, res, e);
                end
            end
        end
        if (w64) start64 = 1'b0; else start32 = 1'b0;
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(lat + 1));
        check({tag, "_busy_profile"}, 64'(busy_bad), 64'd0);
    endtask

    // One idle cycle after a done: done must already be low again
    task automatic idle(input bit w64, input string tag);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(w64 ? done64 : done32), 64'd0);
    endtask

    initial begin
        int ndone;
        rst     = 1'b1;
        start32 = 1'b0;
        start64 = 1'b0;
        funct3  = 3'b000;
        opA     = '0;
        opB     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check("rst_res32",  64'(res32),  64'd0);
        check("rst_busy64", 64'(busy64), 64'd0);
        check("rst_res64",  res64,       64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // XLEN = 32 functional vectors
        run(0, 3'b000, 64'd7,         64'hFFFFFFFD, 64'hFFFFFFEB, 0, "mul");    idle(0, "mul");
        run(0, 3'b001, 64'h80000000,  64'h80000000, 64'h40000000, 0, "mulh");   idle(0, "mulh");
        run(0, 3'b011, 64'hFFFFFFFF,  64'hFFFFFFFF, 64'hFFFFFFFE, 0, "mulhu");  idle(0, "mulhu");
        run(0, 3'b010, 64'hFFFFFFFF,  64'hFFFFFFFF, 64'hFFFFFFFF, 0, "mulhsu"); idle(0, "mulhsu");
        run(0, 3'b100, 64'hFFFFFFF9,  64'd2,        64'hFFFFFFFD, 0, "div");    idle(0, "div");
        run(0, 3'b110, 64'hFFFFFFF9,  64'd2,        64'hFFFFFFFF, 0, "rem");    idle(0, "rem");
        run(0, 3'b101, 64'hFFFFFFF9,  64'd2,        64'h7FFFFFFC, 0, "divu");   idle(0, "divu");
        run(0, 3'b101, 64'd5,         64'd0,        64'hFFFFFFFF, 0, "divu0");  idle(0, "divu0");
        run(0, 3'b111, 64'd5,         64'd0,        64'd5,        0, "remu0");  idle(0, "remu0");
        run(0, 3'b100, 64'hFFFFFFF9,  64'd0,        64'hFFFFFFFF, 0, "div0");   idle(0, "div0");
        run(0, 3'b110, 64'hFFFFFFF9,  64'd0,        64'hFFFFFFF9, 0, "rem0");   idle(0, "rem0");
        run(0, 3'b100, 64'h80000000,  64'hFFFFFFFF, 64'h80000000, 0, "divovf"); idle(0, "divovf");
        run(0, 3'b110, 64'h80000000,  64'hFFFFFFFF, 64'd0,        0, "removf"); idle(0, "removf");

        // start pulsed in cycle 10 must be ignored: exactly one done
        run(0, 3'b000, 64'd12345, 64'd678, 64'd8369910, 1, "poke");
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) ndone++;
        end
        check("poke_extra_done", 64'(ndone), 64'd0);

        // Back-to-back: second request issued in the done cycle of the first
        run(0, 3'b000, 64'd100, 64'd200, 64'd20000, 0, "chain1");
        run(0, 3'b101, 64'd100, 64'd7,   64'd14,    0, "chain2");
        idle(0, "chain2");

        // rst and start together: reset wins
        start32 = 1'b1;
        funct3  = 3'b000;
        opA     = 64'd3;
        opB     = 64'd3;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        start32 = 1'b0;
        check("rst_start_busy", 64'(busy32), 64'd0);
        check("rst_start_res",  64'(res32),  64'd0);

        // Reset in cycle 15 of an operation: aborted, no done, result cleared
        run(0, 3'b000, 64'd9, 64'd9, 64'd81, 0, "pre_abort");
        idle(0, "pre_abort");
        start32 = 1'b1;
        funct3  = 3'b011;
        opA     = 64'h12345678;
        opB     = 64'h9ABCDEF0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            start32 = 1'b0;
            if (c == 15) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_res",  64'(res32),  64'd0);
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_res_hold", 64'(res32), 64'd0);

        // XLEN = 64 vectors
        run(1, 3'b000, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 0, "mul64");  idle(1, "mul64");
        run(1, 3'b001, 64'h8000000000000000, 64'h8000000000000000,
               64'h4000000000000000, 0, "mulh64");                                      idle(1, "mulh64");
        run(1, 3'b100, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 0, "div64");  idle(1, "div64");
        run(1, 3'b110, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 0, "rem64");  idle(1, "rem64");
        run(1, 3'b100, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
               64'h8000000000000000, 0, "divovf64");                                    idle(1, "divovf64");
        run(1, 3'b101, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0, "divu0_64");              idle(1, "divu0_64");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply/divide unit, parametrised in operand width. It sits beside the ALU in the execute path. Operands come from the register-file read ports, `funct3` comes from the instruction, and `result` feeds the write-back mux. The core holds `PCnext` and suppresses `RegWrite` while `busy` is high, and writes `result` in the cycle `done` is high. One operation is in flight at a time, and every operation has the same fixed latency.

## Interface
- `XLEN`, default 32: operand/result width; any even value ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy` = 0.
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opA`  in  XLEN  rs1 value (multiplicand / dividend).
- `opB`  in  XLEN  rs2 value (multiplier / divisor).
- `busy`  out  1  high while the operation iterates.
- `done`  out  1  single-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  registered result; held until the next accepted `start` completes.

## Operation
- **States.** IDLE → CALC → DONE → IDLE. From DONE, a `start` moves directly to CALC.
- **Accept.** In IDLE or DONE with `start` = 1, the unit registers `funct3`, `opA` and `opB`. It records the signs: A is signed for MULH, MULHSU, DIV and REM; B is signed for MULH, DIV and REM. It replaces each signed negative operand with its magnitude, loads the counter with XLEN−1, and enters CALC.
- **CALC, multiply.** Unsigned shift-add into a 2·XLEN accumulator, one multiplier bit per cycle.
- **CALC, divide.** Restoring division, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
- **CALC, exit.** The counter decrements every cycle. After the cycle in which the counter is 0, the unit enters DONE.
- **Sign fix, on the CALC→DONE edge.**
  - Product: negated over the full 2·XLEN bits if signA ^ signB.
  - Quotient: negated if signA ^ signB.
  - Remainder: negated if signA.
- **Result select.**
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits of the product.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- **Divide by zero** (opB = 0): quotient = all ones, remainder = opA unmodified. This applies to signed and unsigned ops.
- **Signed overflow** (DIV/REM with opA = 1 followed by XLEN−1 zeros, opB = all ones): quotient = opA, remainder = 0.
- **Special-case latency.** Divide by zero and signed overflow take the normal latency; there is no early exit.
- **`start` in CALC.** Ignored and not queued. `opA`, `opB` and `funct3` changes after acceptance have no effect.
- **Reset mid-operation.** Aborts the operation. No `done` pulse is produced and `result` is cleared.

## Timing
- **Reset values:** state IDLE, `busy` = 0, `done` = 0, `result` = 0, counter = 0, all internal registers 0.
- **Cycle numbering.** Cycle 0 is the cycle in which `start` is sampled high with `busy` = 0.
- **`busy`** is high in cycles 1 through XLEN, i.e. exactly XLEN cycles.
- **`done`** is high in cycle XLEN+1 only. `busy` is 0 in that cycle.
- **`result`** changes only on the CALC→DONE edge and is stable from cycle XLEN+1 onward.
- **Throughput.** With `start` high in the DONE cycle, the next operation has `busy` high in the following cycle, giving one operation per XLEN+1 cycles.
- **`rst` and `start` high together:** reset wins and the request is dropped.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **MUL, XLEN = 32.** `start` with funct3 = 000, opA = 7, opB = 0xFFFFFFFD → `busy` high in cycles 1–32, `done` in cycle 33 only, `result` = 0xFFFFFFEB.
- **High-half multiplies.**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide and remainder.**
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- **Corner cases.**
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - All of these have `done` exactly in cycle 33.
- **Handshake.**
  - `start` pulsed at cycle 10 during a busy operation → ignored; exactly one `done`, in cycle 33.
  - `start` asserted in the cycle 33 `done` cycle → second op busy in cycles 34–65, `done` in cycle 66.
- **Reset and parametrisation.**
  - `rst` asserted at cycle 15 → `busy` = 0, `done` stays 0 for the remainder of the run, `result` = 0.
  - Repeat the MUL and DIV vectors with XLEN = 64 → `done` in cycle 65, with correct sign-extended results.
